// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, Rcon table, controller states and GF(2^8) arithmetic.
package aes_pkg;

  localparam int unsigned Nr = 10;

  localparam logic [7:0] RconTable [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {StIdle, StKeyExp, StRound} aes_state_e;

  // Round constant for key-schedule step 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] val;
    val = 8'h00;
    if (round >= 4'd1 && round <= 4'd10) begin
      val = RconTable[round];
    end
    return val;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end
      sh = xtime(sh);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward/inverse AES S-box by table lookup; inv_i selects the inverse table.
module aes_sbox (
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  // Entry 0 sits in the most significant byte of each table.
  localparam logic [2047:0] SboxFwd = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SboxInv = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] top_bit;

  // 2047 - 8*x, i.e. the top bit of entry x.
  assign top_bit = ~{data_i, 3'b000};
  assign data_o  = inv_i ? SboxInv[top_bit -: 8] : SboxFwd[top_bit -: 8];

endmodule

// File: rtl/aes_decrypt.sv
// AES-128 inverse cipher, one round per cycle; round keys are expanded forward once and then
// unwound backwards during the rounds so only the current round key is stored.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LastStep = 4'(Nr);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  aes_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] data_q, data_d;
  logic [127:0] ciphertext_q, ciphertext_d;
  logic         done_q, done_d;

  // Key schedule: one shared SubWord(RotWord()) for both directions.
  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [31:0]  ks_word, ks_sbox_in, ks_sub, ks_t;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [127:0] fwd_key, bwd_key;

  assign {kw0, kw1, kw2, kw3} = rk_q;

  // Going backwards, word 3 of the previous key is w3 ^ w2 of the current one.
  assign ks_word    = (state_q == StRound) ? (kw3 ^ kw2) : kw3;
  assign ks_sbox_in = {ks_word[23:0], ks_word[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .data_i (ks_sbox_in[8*i +: 8]),
      .inv_i  (1'b0),
      .data_o (ks_sub[8*i +: 8])
    );
  end

  assign ks_t    = ks_sub ^ {rcon(cnt_q), 24'h000000};
  assign fw0     = kw0 ^ ks_t;
  assign fw1     = kw1 ^ fw0;
  assign fw2     = kw2 ^ fw1;
  assign fw3     = kw3 ^ fw2;
  assign fwd_key = {fw0, fw1, fw2, fw3};
  assign bwd_key = {kw0 ^ ks_t, kw1 ^ kw0, kw2 ^ kw1, kw3 ^ kw2};

  // Round datapath.
  logic [127:0] isr, isb, ark, imc, round_out;

  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(4*c+r) -: 8] = data_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_data_sbox
    aes_sbox u_sbox (
      .data_i (isr[8*i +: 8]),
      .inv_i  (1'b1),
      .data_o (isb[8*i +: 8])
    );
  end

  assign ark = isb ^ bwd_key;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign round_out = (cnt_q == 4'd1) ? ark : imc;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    rk_d         = rk_q;
    data_d       = data_q;
    ciphertext_d = ciphertext_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          blk_d   = plaintext;
          rk_d    = key;
          cnt_d   = 4'd1;
          state_d = StKeyExp;
        end
      end
      StKeyExp: begin
        rk_d = fwd_key;
        if (cnt_q == LastStep) begin
          data_d  = blk_q ^ fwd_key;
          state_d = StRound;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRound: begin
        rk_d   = bwd_key;
        data_d = round_out;
        if (cnt_q == 4'd1) begin
          ciphertext_d = round_out;
          done_d       = 1'b1;
          cnt_d        = 4'd0;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      blk_q        <= '0;
      rk_q         <= '0;
      data_q       <= '0;
      ciphertext_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      rk_q         <= rk_d;
      data_q       <= data_d;
      ciphertext_q <= ciphertext_d;
      done_q       <= done_d;
    end
  end

  assign ciphertext = ciphertext_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 vectors, round trip through a reference encryptor,
// start-while-busy, mid-operation reset and back-to-back operation.
module tb_aes_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  localparam logic [127:0] KeyC1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] InC1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] OutC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] InB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] OutB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] TextRt = 128'h48656c6c6f21;
  localparam logic [127:0] KeyRt  = 128'h6b65790a;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] sb_tab [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = m_xtime(sh);
    end
    return acc;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (m_gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] rk, s, t;
    logic [31:0]  w, tw, n0, n1, n2, n3, col;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = k;
    s  = pt ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w  = rk[31:0];
      tw = {sb_tab[w[23:16]] ^ rc, sb_tab[w[15:8]], sb_tab[w[7:0]], sb_tab[w[31:24]]};
      n0 = rk[127:96] ^ tw;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      rk = {n0, n1, n2, n3};
      rc = m_xtime(rc);
      t  = '0;
      for (int c = 0; c < 4; c++) begin
        for (int rw = 0; rw < 4; rw++) begin
          t[127-8*(4*c+rw) -: 8] = sb_tab[s[127-8*(4*((c+rw)%4)+rw) -: 8]];
        end
      end
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          col = t[127-32*c -: 32];
          {a0, a1, a2, a3} = col;
          t[127-32*c -: 32] = {m_xtime(a0) ^ m_xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ m_xtime(a1) ^ m_xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ m_xtime(a2) ^ m_xtime(a3) ^ a3,
                               m_xtime(a0) ^ a0 ^ a1 ^ a2 ^ m_xtime(a3)};
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  task automatic run_op(input string tag, input logic [127:0] din, input logic [127:0] k,
                        input logic [127:0] exp, input bit disturb);
    int lat;
    bit seen;
    @(negedge clk);
    plaintext = din;
    key       = k;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    plaintext = ~din;
    key       = ~k;
    check({tag, " busy"}, 128'(busy), 128'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (disturb && lat == 5) begin
        start     = 1'b1;
        plaintext = InB;
        key       = KeyB;
      end
      if (disturb && lat == 16) start = 1'b0;
      seen = done;
    end
    check({tag, " latency"}, 128'(lat), 128'd20);
    check({tag, " result"}, ciphertext, exp);
    @(negedge clk);
    check({tag, " done width"}, 128'(done), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_done;
    int k;
    int t;
    int t_done [3];
    logic [127:0] rt_ct;
    logic [127:0] b2b_in  [3];
    logic [127:0] b2b_key [3];
    logic [127:0] b2b_exp [3];

    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    for (int i = 0; i < 256; i++) sb_tab[i] = m_sbox(8'(i));
    rt_ct = m_enc(TextRt, KeyRt);

    repeat (2) @(negedge clk);
    check("reset ciphertext", ciphertext, 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset done", 128'(done), 128'd0);
    rst = 1'b0;

    run_op("fips c1", InC1, KeyC1, OutC1, 1'b0);
    run_op("fips b", InB, KeyB, OutB, 1'b0);
    run_op("round trip", rt_ct, KeyRt, TextRt, 1'b0);

    run_op("start while busy", InC1, KeyC1, OutC1, 1'b1);
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("start while busy extra done", 128'(n_done), 128'd0);

    // Abort at cycle 12; ciphertext holds OutC1 so the clear is observable.
    @(negedge clk);
    plaintext = InB;
    key       = KeyB;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort ciphertext", ciphertext, 128'd0);
    check("abort busy", 128'(busy), 128'd0);
    check("abort done", 128'(done), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", 128'(n_done), 128'd0);
    run_op("after reset", InC1, KeyC1, OutC1, 1'b0);

    b2b_in[0]  = InC1;  b2b_key[0] = KeyC1; b2b_exp[0] = OutC1;
    b2b_in[1]  = InB;   b2b_key[1] = KeyB;  b2b_exp[1] = OutB;
    b2b_in[2]  = rt_ct; b2b_key[2] = KeyRt; b2b_exp[2] = TextRt;
    t_done = '{0, 0, 0};
    @(negedge clk);
    plaintext = b2b_in[0];
    key       = b2b_key[0];
    start     = 1'b1;
    k = 0;
    t = 0;
    while (k < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (done) begin
        check($sformatf("b2b result %0d", k), ciphertext, b2b_exp[k]);
        t_done[k] = t;
        k++;
        if (k < 3) begin
          plaintext = b2b_in[k];
          key       = b2b_key[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b done count", 128'(k), 128'd3);
    check("b2b spacing 0-1", 128'(t_done[1] - t_done[0]), 128'd21);
    check("b2b spacing 1-2", 128'(t_done[2] - t_done[1]), 128'd21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
